// File: rtl/rfm_bank_scheduler.sv
// Routes ACTs to per-bank RFM tracker units, keeps per-bank rolling ACT counts and
// arbitrates a single RFM slot at a time with the memory controller.
//   state | meaning
//   IDLE  | scanning for an RFM-eligible bank
//   REQ   | rfm_req raised for sel, waiting for rfm_gnt
//   ISSUE | granted; waits for sel's ACT gap to clear, then fires bank_rfm
//   WAIT  | waiting for sel's nrr, bounded by the timeout counter
module rfm_bank_scheduler #(
  parameter int NUM_BANK  = 4,
  parameter int BANK_BITS = 2,
  parameter int ADDR_SIZE = 18,
  parameter int RAA_SIZE  = 8,
  parameter int RFM_TH    = 8,
  parameter int RAA_MAX   = 32,
  parameter int ACT_GAP   = 4,
  parameter int TIMEOUT   = 16
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 act_in,
  input  logic [BANK_BITS-1:0] act_bank_in,
  input  logic [ADDR_SIZE-1:0] act_addr_in,
  output logic [NUM_BANK-1:0]  bank_act,
  output logic [ADDR_SIZE-1:0] bank_act_addr,
  output logic [NUM_BANK-1:0]  bank_rfm,
  input  logic [NUM_BANK-1:0]  bank_nrr,
  output logic                 rfm_req,
  output logic [BANK_BITS-1:0] rfm_req_bank,
  input  logic                 rfm_gnt,
  output logic [NUM_BANK-1:0]  act_block,
  output logic                 act_drop,
  output logic                 rfm_timeout
);

  localparam int GAP_W  = $clog2(ACT_GAP + 1);
  localparam int WAIT_W = $clog2(TIMEOUT + 1);
  localparam logic [RAA_SIZE-1:0] TH      = RAA_SIZE'(RFM_TH);
  localparam logic [RAA_SIZE-1:0] MAX     = RAA_SIZE'(RAA_MAX);
  localparam logic [GAP_W-1:0]    GAP_LD  = GAP_W'(ACT_GAP);
  localparam logic [WAIT_W-1:0]   WAIT_LD = WAIT_W'(TIMEOUT);

  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, ISSUE = 2'd2, WAIT = 2'd3} state_t;

  state_t               state, state_nxt;
  logic [BANK_BITS-1:0] sel, sel_nxt;
  logic [WAIT_W-1:0]    wait_cnt, wait_cnt_nxt;
  logic [RAA_SIZE-1:0]  raa [NUM_BANK];
  logic [RAA_SIZE-1:0]  raa_nxt [NUM_BANK];
  logic [GAP_W-1:0]     gap [NUM_BANK];
  logic [GAP_W-1:0]     gap_nxt [NUM_BANK];
  logic [NUM_BANK-1:0]  act_vec, rfm_vec, block_nxt;
  logic                 accept, owned_bank, rfm_dec, timeout_nxt;
  logic                 pick_valid;
  logic [BANK_BITS-1:0] pick;
  logic [RAA_SIZE-1:0]  pick_raa;

  assign rfm_req      = (state == REQ);
  assign rfm_req_bank = sel;

  // The bank being refreshed may not take ACTs, so RAA never sees inc and dec together.
  assign owned_bank = (state == ISSUE || state == WAIT) && (sel == act_bank_in);
  assign accept     = act_in && (gap[act_bank_in] == '0) && !owned_bank;

  always_comb begin
    pick_valid = 1'b0;
    pick       = '0;
    pick_raa   = '0;
    for (int i = 0; i < NUM_BANK; i++) begin
      if (raa[i] >= TH && gap[i] == '0 && (!pick_valid || raa[i] > pick_raa)) begin
        pick_valid = 1'b1;
        pick       = BANK_BITS'(i);
        pick_raa   = raa[i];
      end
    end
  end

  always_comb begin
    state_nxt    = state;
    sel_nxt      = sel;
    wait_cnt_nxt = wait_cnt;
    rfm_vec      = '0;
    rfm_dec      = 1'b0;
    timeout_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (pick_valid) begin
          state_nxt = REQ;
          sel_nxt   = pick;
        end
      end
      REQ: begin
        if (rfm_gnt) state_nxt = ISSUE;
      end
      ISSUE: begin
        if (gap[sel] == '0) begin
          rfm_vec[sel] = 1'b1;
          rfm_dec      = 1'b1;
          wait_cnt_nxt = WAIT_LD;
          state_nxt    = WAIT;
        end
      end
      WAIT: begin
        if (bank_nrr[sel]) begin
          state_nxt = IDLE;
        end else if (wait_cnt == WAIT_W'(1)) begin
          timeout_nxt = 1'b1;
          state_nxt   = IDLE;
        end else begin
          wait_cnt_nxt = wait_cnt - WAIT_W'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    for (int i = 0; i < NUM_BANK; i++) begin
      raa_nxt[i] = raa[i];
      gap_nxt[i] = gap[i];
      act_vec[i] = 1'b0;
      if (accept && act_bank_in == BANK_BITS'(i)) begin
        act_vec[i] = 1'b1;
        gap_nxt[i] = GAP_LD;
        if (raa[i] != '1) raa_nxt[i] = raa[i] + RAA_SIZE'(1);
      end else if (gap[i] != '0) begin
        gap_nxt[i] = gap[i] - GAP_W'(1);
      end
      if (rfm_dec && sel == BANK_BITS'(i)) raa_nxt[i] = (raa[i] >= TH) ? raa[i] - TH : '0;
      block_nxt[i] = (raa_nxt[i] >= MAX);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= IDLE;
      sel      <= '0;
      wait_cnt <= '0;
    end else begin
      state    <= state_nxt;
      sel      <= sel_nxt;
      wait_cnt <= wait_cnt_nxt;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < NUM_BANK; i++) begin
        raa[i] <= '0;
        gap[i] <= '0;
      end
      bank_act      <= '0;
      bank_act_addr <= '0;
      bank_rfm      <= '0;
      act_block     <= '0;
      act_drop      <= 1'b0;
      rfm_timeout   <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_BANK; i++) begin
        raa[i] <= raa_nxt[i];
        gap[i] <= gap_nxt[i];
      end
      bank_act  <= act_vec;
      if (accept) bank_act_addr <= act_addr_in;
      bank_rfm    <= rfm_vec;
      act_block   <= block_nxt;
      act_drop    <= act_in && !accept;
      rfm_timeout <= timeout_nxt;
    end
  end

endmodule

// File: tb/tb_rfm_bank_scheduler.sv
// Bench for rfm_bank_scheduler: timestamp-based reference model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_rfm_bank_scheduler;
  localparam int TH = 8, RMAX = 32, GAP = 4, TO = 16;
  localparam int P_IDLE = 0, P_REQ = 1, P_ISSUE = 2, P_WAIT = 3;

  logic        clk = 1'b0, rstn = 1'b0, act_in = 1'b0, rfm_gnt = 1'b0;
  logic [1:0]  act_bank_in = '0;
  logic [17:0] act_addr_in = '0;
  logic [3:0]  bank_nrr = '0;
  logic [3:0]  bank_act, bank_rfm, act_block;
  logic [17:0] bank_act_addr;
  logic        rfm_req, act_drop, rfm_timeout;
  logic [1:0]  rfm_req_bank;

  always #5 clk = ~clk;

  rfm_bank_scheduler dut (
    .clk(clk), .rstn(rstn), .act_in(act_in), .act_bank_in(act_bank_in),
    .act_addr_in(act_addr_in), .bank_act(bank_act), .bank_act_addr(bank_act_addr),
    .bank_rfm(bank_rfm), .bank_nrr(bank_nrr), .rfm_req(rfm_req),
    .rfm_req_bank(rfm_req_bank), .rfm_gnt(rfm_gnt), .act_block(act_block),
    .act_drop(act_drop), .rfm_timeout(rfm_timeout)
  );

  int checks = 0, errors = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: bank busy-ness and timeout are derived from edge timestamps.
  int m_raa [4];
  int m_last [4];
  int m_t, m_ph, m_sel, m_trfm;
  logic [3:0]  e_act, e_rfm;
  logic [17:0] e_addr;
  logic        e_drop, e_to;

  function automatic bit m_busy(input int b);
    return (m_t - m_last[b]) <= GAP;
  endfunction

  task automatic m_reset();
    for (int b = 0; b < 4; b++) begin
      m_raa[b]  = 0;
      m_last[b] = -1000;
    end
    m_t = 0; m_ph = P_IDLE; m_sel = 0; m_trfm = 0;
    e_act = '0; e_rfm = '0; e_addr = '0; e_drop = 1'b0; e_to = 1'b0;
  endtask

  task automatic m_step();
    bit acc;
    int best, dec, ab;
    m_t++;
    ab  = int'(act_bank_in);
    acc = act_in && !m_busy(ab) && !((m_ph == P_ISSUE || m_ph == P_WAIT) && m_sel == ab);
    e_act  = acc ? 4'(1 << ab) : 4'b0;
    if (acc) e_addr = act_addr_in;
    e_drop = act_in && !acc;
    e_rfm  = '0;
    e_to   = 1'b0;
    dec    = -1;
    case (m_ph)
      P_IDLE: begin
        best = -1;
        for (int b = 0; b < 4; b++)
          if (m_raa[b] >= TH && !m_busy(b) && (best < 0 || m_raa[b] > m_raa[best])) best = b;
        if (best >= 0) begin m_ph = P_REQ; m_sel = best; end
      end
      P_REQ: if (rfm_gnt) m_ph = P_ISSUE;
      P_ISSUE: if (!m_busy(m_sel)) begin
        e_rfm = 4'(1 << m_sel); dec = m_sel; m_trfm = m_t; m_ph = P_WAIT;
      end
      default: begin
        if (bank_nrr[m_sel]) m_ph = P_IDLE;
        else if (m_t - m_trfm == TO) begin e_to = 1'b1; m_ph = P_IDLE; end
      end
    endcase
    if (acc) begin
      m_raa[ab]  = (m_raa[ab] < 255) ? m_raa[ab] + 1 : 255;
      m_last[ab] = m_t;
    end
    if (dec >= 0) m_raa[dec] = (m_raa[dec] > TH) ? m_raa[dec] - TH : 0;
  endtask

  initial begin
    m_reset();
    forever begin
      @(posedge clk or negedge rstn);
      if (!rstn) m_reset();
      else m_step();
    end
  end

  initial begin
    logic [3:0] e_blk;
    forever begin
      @(negedge clk);
      for (int b = 0; b < 4; b++) e_blk[b] = (m_raa[b] >= RMAX);
      chk("bank_act", 32'(bank_act), 32'(e_act));
      chk("bank_act_addr", 32'(bank_act_addr), 32'(e_addr));
      chk("bank_rfm", 32'(bank_rfm), 32'(e_rfm));
      chk("rfm_req", 32'(rfm_req), 32'(m_ph == P_REQ));
      chk("rfm_req_bank", 32'(rfm_req_bank), 32'(m_sel));
      chk("act_block", 32'(act_block), 32'(e_blk));
      chk("act_drop", 32'(act_drop), 32'(e_drop));
      chk("rfm_timeout", 32'(rfm_timeout), 32'(e_to));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, errors so far %0d", errors);
    $fatal(1, "watchdog expired");
  end

  task automatic drive_cycle(input bit v, input int b, input logic [17:0] a);
    @(negedge clk);
    act_in = v; act_bank_in = 2'(b); act_addr_in = a;
  endtask

  task automatic act(input int b, input logic [17:0] a);
    drive_cycle(1'b1, b, a);
    drive_cycle(1'b0, b, a);
  endtask

  task automatic idle(input int k);
    repeat (k) @(negedge clk);
  endtask

  task automatic spaced(input int b, input int count, input logic [17:0] base);
    for (int k = 0; k < count; k++) begin
      act(b, base + 18'(k));
      idle(3);
    end
  endtask

  task automatic gnt();
    @(negedge clk); rfm_gnt = 1'b1;
    @(negedge clk); rfm_gnt = 1'b0;
  endtask

  task automatic nrr(input int b);
    @(negedge clk); bank_nrr = 4'(1 << b);
    @(negedge clk); bank_nrr = '0;
  endtask

  task automatic do_reset();
    @(negedge clk); #2 rstn = 1'b0;
    act_in = 1'b0; rfm_gnt = 1'b0; bank_nrr = '0;
    idle(3);
    #2 rstn = 1'b1;
  endtask

  task automatic wait_for(input int which, input string name, output int n);
    bit hit;
    n = 0; hit = 1'b0;
    while (!hit && n < 200) begin
      @(negedge clk);
      n++;
      case (which)
        0:       hit = rfm_req;
        1:       hit = |bank_rfm;
        default: hit = rfm_timeout;
      endcase
    end
    checks++;
    if (!hit) begin
      errors++;
      $display("FAIL %s: not seen within %0d cycles", name, n);
    end
  endtask

  initial begin
    int n, seen;
    idle(2);
    #2 rstn = 1'b1;
    chk("reset_bank_act", 32'(bank_act), 0);
    chk("reset_rfm_req", 32'(rfm_req), 0);

    // T1: eight spaced ACTs to bank 2, full RFM round trip
    act(2, 18'h100);
    chk("t1_first_act", 32'(bank_act), 32'h4);
    chk("t1_first_addr", 32'(bank_act_addr), 32'h100);
    idle(3);
    spaced(2, 7, 18'h101);
    wait_for(0, "t1_req", n);
    chk("t1_req_bank", 32'(rfm_req_bank), 2);
    gnt();
    wait_for(1, "t1_rfm", n);
    chk("t1_bank_rfm", 32'(bank_rfm), 32'h4);
    chk("t1_model_raa2", 32'(m_raa[2]), 0);
    nrr(2);
    @(negedge clk);
    chk("t1_idle_req", 32'(rfm_req), 0);
    chk("t1_model_idle", 32'(m_ph), P_IDLE);

    // T2: RAA {9,12,12,3} built up while bank 0 holds the request; tie goes to bank 1
    do_reset();
    spaced(0, 8, 18'h200);
    wait_for(0, "t2_req0", n);
    chk("t2_req_bank0", 32'(rfm_req_bank), 0);
    for (int r = 0; r < 12; r++) begin
      drive_cycle(r < 9, 0, 18'h300);
      drive_cycle(1'b1, 1, 18'h301);
      drive_cycle(1'b1, 2, 18'h302);
      drive_cycle(r < 3, 3, 18'h303);
      drive_cycle(1'b0, 0, 18'h0);
    end
    chk("t2_model_raa0", 32'(m_raa[0]), 17);
    chk("t2_model_raa1", 32'(m_raa[1]), 12);
    chk("t2_model_raa3", 32'(m_raa[3]), 3);
    gnt();
    wait_for(1, "t2_rfm", n);
    chk("t2_bank_rfm", 32'(bank_rfm), 32'h1);
    chk("t2_model_raa0_after", 32'(m_raa[0]), 9);
    nrr(0);
    wait_for(0, "t2_req1", n);
    chk("t2_tie_bank", 32'(rfm_req_bank), 1);

    // T3: ACT inside the gap is dropped, other bank accepted
    do_reset();
    act(0, 18'h10);
    chk("t3_act0", 32'(bank_act), 32'h1);
    act(0, 18'h11);
    chk("t3_drop", 32'(act_drop), 1);
    chk("t3_drop_no_act", 32'(bank_act), 0);
    chk("t3_addr_held", 32'(bank_act_addr), 32'h10);
    act(1, 18'h12);
    chk("t3_act1", 32'(bank_act), 32'h2);
    chk("t3_addr1", 32'(bank_act_addr), 32'h12);
    chk("t3_model_raa0", 32'(m_raa[0]), 1);

    // T4: 32 ACTs to bank 3 without grant -> blocked; RFM brings it to 24
    do_reset();
    spaced(3, 32, 18'h400);
    chk("t4_block_set", 32'(act_block), 32'h8);
    chk("t4_req_bank", 32'(rfm_req_bank), 3);
    gnt();
    wait_for(1, "t4_rfm", n);
    chk("t4_block_clear", 32'(act_block), 0);
    chk("t4_model_raa3", 32'(m_raa[3]), 24);
    nrr(3);

    // T5: grant right after an ACT stalls ISSUE; WAIT bank drops ACTs; nrr never comes
    do_reset();
    spaced(1, 8, 18'h500);
    wait_for(0, "t5_req", n);
    act(1, 18'h510);
    gnt();
    wait_for(1, "t5_rfm", n);
    chk("t5_bank_rfm", 32'(bank_rfm), 32'h2);
    act(1, 18'h511);
    chk("t5_wait_drop", 32'(act_drop), 1);
    // two negedges already spent on the ACT, so 14 remain of the 16-cycle timeout
    wait_for(2, "t5_timeout", n);
    chk("t5_timeout_delay", 32'(n), 14);
    @(negedge clk);
    chk("t5_timeout_pulse", 32'(rfm_timeout), 0);
    chk("t5_idle_req", 32'(rfm_req), 0);

    // T6: reset during WAIT clears everything immediately and cleanly
    do_reset();
    spaced(0, 8, 18'h600);
    wait_for(0, "t6_req", n);
    gnt();
    wait_for(1, "t6_rfm", n);
    idle(5);
    #2 rstn = 1'b0;
    #1;
    chk("t6_rst_rfm", 32'(bank_rfm), 0);
    chk("t6_rst_addr", 32'(bank_act_addr), 0);
    chk("t6_rst_req", 32'(rfm_req), 0);
    chk("t6_rst_block", 32'(act_block), 0);
    chk("t6_rst_to", 32'(rfm_timeout), 0);
    idle(3);
    #2 rstn = 1'b1;
    seen = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (rfm_timeout || rfm_req) seen++;
    end
    chk("t6_no_pulse", 32'(seen), 0);
    chk("t6_model_raa", 32'(m_raa[0] + m_raa[1] + m_raa[2] + m_raa[3]), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
